// File: rtl/decoding_block_if.sv
// rtl/decoding_block_if.sv - symbol-in / byte-out handshake bundle for decoding_block
interface decoding_block_if;
  logic         enable_deser;
  logic [131:0] lane_0_rx_enc;
  logic [131:0] lane_1_rx_enc;
  logic [7:0]   lane_0_rx;
  logic [7:0]   lane_1_rx;
  logic         rx_valid;
  logic         sym_start;
  logic         sym_type;
  logic         sync_err;
  logic         overflow;

  modport slave (
    input  enable_deser, lane_0_rx_enc, lane_1_rx_enc,
    output lane_0_rx, lane_1_rx, rx_valid, sym_start, sym_type, sync_err, overflow
  );

  modport master (
    output enable_deser, lane_0_rx_enc, lane_1_rx_enc,
    input  lane_0_rx, lane_1_rx, rx_valid, sym_start, sym_type, sync_err, overflow
  );
endinterface

// File: rtl/decoding_block.sv
// rtl/decoding_block.sv - two-lane Gen2/Gen3 symbol to byte serializer with Gen4 bypass
// One active symbol drains a byte per cycle; a one-entry pending slot absorbs an early strobe.
module decoding_block (
  input  logic             dec_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       gen_speed,
  decoding_block_if.slave  dec
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [131:0] act0_q, act0_d, act1_q, act1_d;
  logic [131:0] pend0_q, pend0_d, pend1_q, pend1_d;
  logic         act_g3_q, act_g3_d, act_type_q, act_type_d;
  logic         pend_vld_q, pend_vld_d, pend_g3_q, pend_g3_d, pend_type_q, pend_type_d;
  logic [7:0]   rx0_q, rx0_d, rx1_q, rx1_d;
  logic         vld_q, vld_d, start_q, start_d, type_q, type_d;
  logic         serr_q, serr_d, ovf_q, ovf_d;

  // {header_ok, symbol_type}; modes 0 and 3 never produce a valid header
  function automatic logic [1:0] hdr_chk(input logic [3:0] h, input logic [1:0] g);
    logic [1:0] r;
    r = 2'b00;
    if (g == 2'd1) begin
      if (h == 4'b0101) r = 2'b10;
      else if (h == 4'b1010) r = 2'b11;
    end else if (g == 2'd2) begin
      if (h[1:0] == 2'b01) r = 2'b10;
      else if (h[1:0] == 2'b10) r = 2'b11;
    end
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [131:0] s, input logic g3,
                                          input logic [3:0] i);
    logic [7:0] amt;
    amt = (g3 ? 8'd4 : 8'd2) + {1'b0, i, 3'b000};
    return 8'(s >> amt);
  endfunction

  logic [1:0] chk0, chk1;
  logic       new_ok, new_bad, new_g4, new_g3, is_last;

  always_comb begin
    chk0    = hdr_chk(dec.lane_0_rx_enc[3:0], gen_speed);
    chk1    = hdr_chk(dec.lane_1_rx_enc[3:0], gen_speed);
    new_ok  = dec.enable_deser && chk0[1] && chk1[1] && (chk0[0] == chk1[0]);
    new_bad = dec.enable_deser && (gen_speed != 2'd0) && !new_ok;
    new_g4  = dec.enable_deser && (gen_speed == 2'd0);
    new_g3  = (gen_speed == 2'd1);
    is_last = (cnt_q == (act_g3_q ? 4'd15 : 4'd7));
  end

  always_ff @(posedge dec_clk) begin
    if (!rst || !enable) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      act0_q      <= '0;
      act1_q      <= '0;
      pend0_q     <= '0;
      pend1_q     <= '0;
      act_g3_q    <= 1'b0;
      act_type_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_g3_q   <= 1'b0;
      pend_type_q <= 1'b0;
      rx0_q       <= 8'd0;
      rx1_q       <= 8'd0;
      vld_q       <= 1'b0;
      start_q     <= 1'b0;
      type_q      <= 1'b0;
      serr_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act0_q      <= act0_d;
      act1_q      <= act1_d;
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
      act_g3_q    <= act_g3_d;
      act_type_q  <= act_type_d;
      pend_vld_q  <= pend_vld_d;
      pend_g3_q   <= pend_g3_d;
      pend_type_q <= pend_type_d;
      rx0_q       <= rx0_d;
      rx1_q       <= rx1_d;
      vld_q       <= vld_d;
      start_q     <= start_d;
      type_q      <= type_d;
      serr_q      <= serr_d;
      ovf_q       <= ovf_d;
    end
  end

  // From IDLE byte 0 leaves with the accepting edge, so the counter starts at 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (new_ok) begin
          state_d = S_DRAIN;
          cnt_d   = 4'd1;
        end
      end
      S_DRAIN: begin
        if (is_last) begin
          cnt_d = 4'd0;
          if (!pend_vld_q && !new_ok) state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    act0_d      = act0_q;
    act1_d      = act1_q;
    act_g3_d    = act_g3_q;
    act_type_d  = act_type_q;
    pend0_d     = pend0_q;
    pend1_d     = pend1_q;
    pend_vld_d  = pend_vld_q;
    pend_g3_d   = pend_g3_q;
    pend_type_d = pend_type_q;
    rx0_d       = 8'd0;
    rx1_d       = 8'd0;
    vld_d       = 1'b0;
    start_d     = 1'b0;
    type_d      = 1'b0;
    serr_d      = new_bad;
    ovf_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (new_ok) begin
          act0_d     = dec.lane_0_rx_enc;
          act1_d     = dec.lane_1_rx_enc;
          act_g3_d   = new_g3;
          act_type_d = chk0[0];
          rx0_d      = get_byte(dec.lane_0_rx_enc, new_g3, 4'd0);
          rx1_d      = get_byte(dec.lane_1_rx_enc, new_g3, 4'd0);
          vld_d      = 1'b1;
          start_d    = 1'b1;
          type_d     = chk0[0];
        end else if (new_g4) begin
          rx0_d   = dec.lane_0_rx_enc[7:0];
          rx1_d   = dec.lane_1_rx_enc[7:0];
          vld_d   = 1'b1;
          start_d = 1'b1;
          type_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        rx0_d   = get_byte(act0_q, act_g3_q, cnt_q);
        rx1_d   = get_byte(act1_q, act_g3_q, cnt_q);
        vld_d   = 1'b1;
        start_d = (cnt_q == 4'd0);
        type_d  = act_type_q;
        // A full slot at the start of the cycle rejects a new symbol even if it empties now
        if (is_last && pend_vld_q) begin
          act0_d     = pend0_q;
          act1_d     = pend1_q;
          act_g3_d   = pend_g3_q;
          act_type_d = pend_type_q;
          pend_vld_d = 1'b0;
          ovf_d      = new_ok;
        end else if (is_last && new_ok) begin
          act0_d     = dec.lane_0_rx_enc;
          act1_d     = dec.lane_1_rx_enc;
          act_g3_d   = new_g3;
          act_type_d = chk0[0];
        end else if (new_ok) begin
          if (!pend_vld_q) begin
            pend0_d     = dec.lane_0_rx_enc;
            pend1_d     = dec.lane_1_rx_enc;
            pend_g3_d   = new_g3;
            pend_type_d = chk0[0];
            pend_vld_d  = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    dec.lane_0_rx = rx0_q;
    dec.lane_1_rx = rx1_q;
    dec.rx_valid  = vld_q;
    dec.sym_start = start_q;
    dec.sym_type  = type_q;
    dec.sync_err  = serr_q;
    dec.overflow  = ovf_q;
  end

endmodule

// File: tb/tb_decoding_block.sv
// tb/tb_decoding_block.sv - directed self-checking bench for decoding_block
module tb_decoding_block;

  logic       dec_clk;
  logic       rst;
  logic       enable;
  logic [1:0] gen_speed;
  int         checks;
  int         failures;

  decoding_block_if dif();

  decoding_block dut (
    .dec_clk   (dec_clk),
    .rst       (rst),
    .enable    (enable),
    .gen_speed (gen_speed),
    .dec       (dif)
  );

  initial dec_clk = 1'b0;
  always #5 dec_clk = ~dec_clk;

  // {rx_valid, sym_start, sym_type, sync_err, overflow, lane_0_rx, lane_1_rx}
  function automatic logic [20:0] obs();
    return {dif.rx_valid, dif.sym_start, dif.sym_type, dif.sync_err, dif.overflow,
            dif.lane_0_rx, dif.lane_1_rx};
  endfunction

  function automatic logic [131:0] build_g3(input logic [3:0] hdr, input logic [7:0] base);
    logic [131:0] s;
    s = '0;
    s[3:0] = hdr;
    for (int i = 0; i < 16; i++) s[4+8*i +: 8] = base + 8'(i);
    return s;
  endfunction

  function automatic logic [131:0] build_g2(input logic [1:0] hdr, input logic [7:0] base);
    logic [131:0] s;
    s = {132{1'b1}};
    s[1:0] = hdr;
    for (int i = 0; i < 8; i++) s[2+8*i +: 8] = base + 8'(i);
    return s;
  endfunction

  task automatic cyc();
    @(posedge dec_clk);
    #1;
  endtask

  task automatic strobe(input logic [131:0] s0, input logic [131:0] s1);
    dif.enable_deser  = 1'b1;
    dif.lane_0_rx_enc = s0;
    dif.lane_1_rx_enc = s1;
  endtask

  task automatic idle_in();
    dif.enable_deser  = 1'b0;
    dif.lane_0_rx_enc = '0;
    dif.lane_1_rx_enc = '0;
  endtask

  task automatic apply_reset();
    idle_in();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    gen_speed = 2'd1;
    strobe(build_g3(4'b1010, 8'h00), build_g3(4'b1010, 8'h80));
    cyc();
    checks++;
    if (obs() !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs(), 21'd0);
    end
    idle_in();
    rst = 1'b1;
    cyc();
    checks++;
    if (obs() !== 21'd0) begin
      failures++;
      $display("FAIL reset_no_leftover got=%h exp=%h", obs(), 21'd0);
    end
  endtask

  task automatic test_gen3_single();
    logic [20:0] exp;
    apply_reset();
    gen_speed = 2'd1;
    strobe(build_g3(4'b1010, 8'h00), build_g3(4'b1010, 8'h80));
    for (int k = 0; k < 16; k++) begin
      cyc();
      idle_in();
      exp = {1'b1, (k == 0), 1'b1, 2'b00, 8'(k), 8'(8'h80 + k)};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL gen3_byte%0d got=%h exp=%h", k, obs(), exp);
      end
    end
    cyc();
    checks++;
    if (obs() !== 21'd0) begin
      failures++;
      $display("FAIL gen3_end_idle got=%h exp=%h", obs(), 21'd0);
    end
  endtask

  task automatic test_gen2_back_to_back();
    logic [20:0] exp;
    logic [7:0]  b;
    apply_reset();
    gen_speed = 2'd2;
    for (int c = 0; c < 24; c++) begin
      if (c % 8 == 0)
        strobe(build_g2(2'b01, 8'(8'h10 * (c / 8 + 1))), build_g2(2'b01, 8'(8'h90 + 8'h10 * (c / 8))));
      else
        idle_in();
      cyc();
      b = 8'(8'h10 * (c / 8 + 1) + c % 8);
      exp = {1'b1, (c % 8 == 0), 1'b0, 2'b00, b, 8'(8'h90 + 8'h10 * (c / 8) + c % 8)};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL gen2_cycle%0d got=%h exp=%h", c, obs(), exp);
      end
    end
    idle_in();
    cyc();
    checks++;
    if (dif.rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL gen2_end_idle got=%b exp=0", dif.rx_valid);
    end
  endtask

  task automatic test_overflow();
    logic [20:0] exp;
    int          nbytes;
    int          novf;
    apply_reset();
    gen_speed = 2'd1;
    nbytes = 0;
    novf = 0;
    for (int c = 0; c < 36; c++) begin
      if (c < 3)
        strobe(build_g3(4'b0101, 8'(8'h40 * c)), build_g3(4'b0101, 8'(8'h40 * c + 8'h20)));
      else
        idle_in();
      cyc();
      if (dif.rx_valid === 1'b1) nbytes++;
      if (dif.overflow === 1'b1) novf++;
      if (c < 16)
        exp = {1'b1, (c == 0), 1'b0, 1'b0, (c == 2), 8'(c), 8'(8'h20 + c)};
      else if (c < 32)
        exp = {1'b1, (c == 16), 1'b0, 2'b00, 8'(8'h40 + c - 16), 8'(8'h60 + c - 16)};
      else
        exp = 21'd0;
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL ovf_cycle%0d got=%h exp=%h", c, obs(), exp);
      end
    end
    checks++;
    if (nbytes !== 32) begin
      failures++;
      $display("FAIL ovf_byte_count got=%0d exp=32", nbytes);
    end
    checks++;
    if (novf !== 1) begin
      failures++;
      $display("FAIL ovf_pulse_count got=%0d exp=1", novf);
    end
  endtask

  task automatic test_sync_err();
    logic [20:0] exp_err;
    exp_err = {3'b000, 1'b1, 1'b0, 16'd0};
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        gen_speed = 2'd1;
        strobe(build_g3(4'b0011, 8'h00), build_g3(4'b0011, 8'h00));
      end else if (t == 1) begin
        gen_speed = 2'd3;
        strobe(build_g3(4'b1010, 8'h00), build_g3(4'b1010, 8'h00));
      end else begin
        gen_speed = 2'd1;
        strobe(build_g3(4'b1010, 8'h00), build_g3(4'b0101, 8'h00));
      end
      cyc();
      idle_in();
      checks++;
      if (obs() !== exp_err) begin
        failures++;
        $display("FAIL sync_err_case%0d got=%h exp=%h", t, obs(), exp_err);
      end
      cyc();
      checks++;
      if (obs() !== 21'd0) begin
        failures++;
        $display("FAIL sync_err_clear%0d got=%h exp=%h", t, obs(), 21'd0);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [20:0] exp;
    apply_reset();
    gen_speed = 2'd1;
    strobe(build_g3(4'b1010, 8'h00), build_g3(4'b1010, 8'h80));
    for (int k = 0; k < 6; k++) begin
      cyc();
      idle_in();
    end
    checks++;
    if (dif.lane_0_rx !== 8'h05) begin
      failures++;
      $display("FAIL mid_pre_byte got=%h exp=05", dif.lane_0_rx);
    end
    rst = 1'b0;
    strobe(build_g3(4'b1010, 8'h30), build_g3(4'b1010, 8'h30));
    cyc();
    checks++;
    if (obs() !== 21'd0) begin
      failures++;
      $display("FAIL mid_reset_clear got=%h exp=%h", obs(), 21'd0);
    end
    rst = 1'b1;
    idle_in();
    cyc();
    checks++;
    if (obs() !== 21'd0) begin
      failures++;
      $display("FAIL mid_after_release got=%h exp=%h", obs(), 21'd0);
    end
    strobe(build_g3(4'b1010, 8'h50), build_g3(4'b1010, 8'hD0));
    cyc();
    idle_in();
    exp = {1'b1, 1'b1, 1'b1, 2'b00, 8'h50, 8'hD0};
    checks++;
    if (obs() !== exp) begin
      failures++;
      $display("FAIL mid_restart got=%h exp=%h", obs(), exp);
    end
    cyc();
    cyc();
    enable = 1'b0;
    cyc();
    checks++;
    if (obs() !== 21'd0) begin
      failures++;
      $display("FAIL enable_clear got=%h exp=%h", obs(), 21'd0);
    end
    enable = 1'b1;
    cyc();
    checks++;
    if (dif.rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL enable_no_resume got=%b exp=0", dif.rx_valid);
    end
  endtask

  task automatic test_gen4();
    logic [131:0] s0, s1;
    logic [20:0]  exp;
    apply_reset();
    gen_speed = 2'd0;
    s0 = '0;
    s1 = '0;
    s0[7:0] = 8'hA5;
    s0[11:8] = 4'hF;
    s1[7:0] = 8'h11;
    strobe(s0, s1);
    cyc();
    exp = {3'b111, 2'b00, 8'hA5, 8'h11};
    checks++;
    if (obs() !== exp) begin
      failures++;
      $display("FAIL gen4_first got=%h exp=%h", obs(), exp);
    end
    s0[7:0] = 8'h3C;
    s1[7:0] = 8'h22;
    strobe(s0, s1);
    cyc();
    idle_in();
    exp = {3'b111, 2'b00, 8'h3C, 8'h22};
    checks++;
    if (obs() !== exp) begin
      failures++;
      $display("FAIL gen4_second got=%h exp=%h", obs(), exp);
    end
    cyc();
    checks++;
    if (obs() !== 21'd0) begin
      failures++;
      $display("FAIL gen4_idle got=%h exp=%h", obs(), 21'd0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    enable = 1'b0;
    gen_speed = 2'd0;
    idle_in();
    #2;
    test_reset();
    test_gen3_single();
    test_gen2_back_to_back();
    test_overflow();
    test_sync_err();
    test_reset_mid_drain();
    test_gen4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
